cia_timer_ctrl: RTL and testbench

Control-register sequencer for the two interval timers (A and B). Holds CRA/CRB, drives each timer's control bundle (start, count, force_load, toggle), and selects the count source: PHI2, CNT edges, or timer A underflow for timer B. Implements one-shot auto-stop on underflow and the write-only LOAD strobe. Sits between the register decode and the two timer instances.

---
 rtl/cia_timer_ctrl.sv | 116 +++++++++++
 tb/tb_cia_timer_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cia_timer_ctrl.sv
// CIA timer control registers (CRA/CRB).
// Holds both control registers and produces each timer's control bundle.
// Also selects the count source, applies one-shot auto-stop and generates
// the LOAD strobe. All architectural state advances only on phi2_dn.
// The CNT synchronizer is the exception and samples on every clk.

package cia;
    typedef struct packed {
        logic start;
        logic count;
        logic force_load;
        logic toggle;
    } tctrl_t;
endpackage

module cia_timer_ctrl #(
    parameter int CNT_SYNC = 2
) (
    input  logic         clk,
    input  logic         res,
    input  logic         phi2_dn,
    input  logic         cra_w,
    input  logic         crb_w,
    input  logic [7:0]   data,
    input  logic         cnt,
    input  logic         ta_ufl,
    input  logic         tb_ufl,
    output logic [7:0]   cra,
    output logic [7:0]   crb,
    output cia::tctrl_t  ctrl_a,
    output cia::tctrl_t  ctrl_b,
    output logic         pbon_a,
    output logic         pbon_b,
    output logic         spmode,
    output logic         todin,
    output logic         alarm
);

    logic [CNT_SYNC-1:0] cnt_sync;
    logic                cnt_prev;
    logic                sync;
    logic                cnt_edge;

    logic [7:0] cra_q, crb_q;
    logic       fl_a, fl_b;
    logic       count_a, count_b;

    logic       a_start_nx, b_start_nx;
    logic       a_mode_nx;
    logic [1:0] b_mode_nx;
    logic       a_src, b_src;

    assign sync     = cnt_sync[CNT_SYNC-1];
    assign cnt_edge = sync & ~cnt_prev;

    // CNT pin synchronizer, free-running on clk
    always_ff @(posedge clk) begin
        if (res) begin
            cnt_sync <= '0;
        end else begin
            cnt_sync[0] <= cnt;
            for (int i = 1; i < CNT_SYNC; i++)
                cnt_sync[i] <= cnt_sync[i-1];
        end
    end

    // Post-update START/INMODE and the selected count source for each timer
    always_comb begin
        // A written START overrides a coincident one-shot underflow stop
        a_start_nx = cra_w ? data[0] : (cra_q[0] & ~(ta_ufl & cra_q[3]));
        b_start_nx = crb_w ? data[0] : (crb_q[0] & ~(tb_ufl & crb_q[3]));
        a_mode_nx  = cra_w ? data[5]   : cra_q[5];
        b_mode_nx  = crb_w ? data[6:5] : crb_q[6:5];
        a_src      = a_mode_nx ? cnt_edge : 1'b1;
        case (b_mode_nx)
            2'b00:   b_src = 1'b1;
            2'b01:   b_src = cnt_edge;
            2'b10:   b_src = ta_ufl;
            default: b_src = ta_ufl & sync;
        endcase
    end

    // Control registers, LOAD strobes, count enables and CNT edge history
    always_ff @(posedge clk) begin
        if (res) begin
            cra_q    <= '0;
            crb_q    <= '0;
            fl_a     <= 1'b0;
            fl_b     <= 1'b0;
            count_a  <= 1'b0;
            count_b  <= 1'b0;
            cnt_prev <= 1'b1;  // suppress a false edge right after reset
        end else if (phi2_dn) begin
            if (cra_w) cra_q[7:1] <= {data[7:5], 1'b0, data[3:1]};
            if (crb_w) crb_q[7:1] <= {data[7:5], 1'b0, data[3:1]};
            cra_q[0] <= a_start_nx;
            crb_q[0] <= b_start_nx;
            fl_a     <= cra_w & data[4];
            fl_b     <= crb_w & data[4];
            count_a  <= a_start_nx & a_src;
            count_b  <= b_start_nx & b_src;
            cnt_prev <= sync;
        end
    end

    assign cra    = cra_q;
    assign crb    = crb_q;
    assign ctrl_a = '{start: cra_q[0], count: count_a, force_load: fl_a, toggle: cra_q[2]};
    assign ctrl_b = '{start: crb_q[0], count: count_b, force_load: fl_b, toggle: crb_q[2]};
    assign pbon_a = cra_q[1];
    assign pbon_b = crb_q[1];
    assign spmode = cra_q[6];
    assign todin  = cra_q[7];
    assign alarm  = crb_q[7];

endmodule

// File: tb/tb_cia_timer_ctrl.sv
// Self-checking bench for cia_timer_ctrl: directed test-plan sequences
// followed by random traffic, compared against a tick-level reference model.

module tb_cia_timer_ctrl;

    logic        clk = 1'b0;
    logic        res, phi2_dn, cra_w, crb_w, cnt, ta_ufl, tb_ufl;
    logic [7:0]  data, cra, crb;
    cia::tctrl_t ctrl_a, ctrl_b;
    logic        pbon_a, pbon_b, spmode, todin, alarm;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state (one entry per PHI2 tick)
    logic [7:0] m_cra, m_crb;
    logic       m_fl_a, m_fl_b, m_cnt_a, m_cnt_b, m_prev;
    int         pulses_a, pulses_b;

    always #5 clk = ~clk;

    cia_timer_ctrl #(.CNT_SYNC(2)) dut (
        .clk(clk), .res(res), .phi2_dn(phi2_dn), .cra_w(cra_w), .crb_w(crb_w),
        .data(data), .cnt(cnt), .ta_ufl(ta_ufl), .tb_ufl(tb_ufl),
        .cra(cra), .crb(crb), .ctrl_a(ctrl_a), .ctrl_b(ctrl_b),
        .pbon_a(pbon_a), .pbon_b(pbon_b), .spmode(spmode), .todin(todin), .alarm(alarm)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":cra"}, cra, m_cra);
        chk({tag, ":crb"}, crb, m_crb);
        chk({tag, ":ctrl_a"}, {ctrl_a.start, ctrl_a.count, ctrl_a.force_load, ctrl_a.toggle},
            {m_cra[0], m_cnt_a, m_fl_a, m_cra[2]});
        chk({tag, ":ctrl_b"}, {ctrl_b.start, ctrl_b.count, ctrl_b.force_load, ctrl_b.toggle},
            {m_crb[0], m_cnt_b, m_fl_b, m_crb[2]});
        chk({tag, ":misc"}, {pbon_a, pbon_b, spmode, todin, alarm},
            {m_cra[1], m_crb[1], m_cra[6], m_cra[7], m_crb[7]});
    endtask

    task automatic do_reset();
        res = 1'b1;
        repeat (2) @(posedge clk);
        #1 res = 1'b0;
        m_cra = 0; m_crb = 0; m_fl_a = 0; m_fl_b = 0;
        m_cnt_a = 0; m_cnt_b = 0; m_prev = 1'b1;
        check_all("reset");
    endtask

    // Reference: derive the next PHI2-cycle state from the control-register rules
    task automatic model(input logic wa, input logic wb, input logic [7:0] d,
                         input logic ta, input logic tb);
        logic s, e, srcb;
        s = cnt;  // cnt is held for >= 3 clks before each tick, so it equals the synced value
        e = s && !m_prev;
        m_fl_a = wa && d[4];
        m_fl_b = wb && d[4];
        if (wa) m_cra = d & 8'hEF;
        else if (ta && m_cra[3]) m_cra[0] = 1'b0;
        if (wb) m_crb = d & 8'hEF;
        else if (tb && m_crb[3]) m_crb[0] = 1'b0;
        m_cnt_a = m_cra[0] && (m_cra[5] ? e : 1'b1);
        case (m_crb[6:5])
            2'd0: srcb = 1'b1;
            2'd1: srcb = e;
            2'd2: srcb = ta;
            default: srcb = ta && s;
        endcase
        m_cnt_b = m_crb[0] && srcb;
        m_prev  = s;
    endtask

    // One PHI2 cycle: three idle clks, then a single-clk phi2_dn strobe
    task automatic tick(input string tag, input logic wa, input logic wb,
                        input logic [7:0] d, input logic ta, input logic tb);
        repeat (3) @(posedge clk);
        #1;
        phi2_dn = 1'b1; cra_w = wa; crb_w = wb; data = d; ta_ufl = ta; tb_ufl = tb;
        @(posedge clk);
        #1;
        phi2_dn = 1'b0; cra_w = 1'b0; crb_w = 1'b0; ta_ufl = 1'b0; tb_ufl = 1'b0;
        model(wa, wb, d, ta, tb);
        check_all(tag);
        pulses_a += int'(ctrl_a.count);
        pulses_b += int'(ctrl_b.count);
    endtask

    initial begin
        res = 1'b0; phi2_dn = 1'b0; cra_w = 1'b0; crb_w = 1'b0;
        data = 8'h00; cnt = 1'b0; ta_ufl = 1'b0; tb_ufl = 1'b0;
        pulses_a = 0; pulses_b = 0;
        @(posedge clk); #1;
        do_reset();

        // 1: start + LOAD
        tick("t1w", 1, 0, 8'h11, 0, 0);
        chk("t1:cra", cra, 8'h01);
        chk("t1:fl", ctrl_a.force_load, 1'b1);
        chk("t1:count", ctrl_a.count, 1'b1);
        tick("t1n", 0, 0, 8'h00, 0, 0);
        chk("t1:fl_clr", ctrl_a.force_load, 1'b0);

        // 2: one-shot underflow stops timer A
        tick("t2w", 1, 0, 8'h09, 0, 0);
        tick("t2u", 0, 0, 8'h00, 1, 0);
        chk("t2:cra", cra, 8'h08);
        chk("t2:start", ctrl_a.start, 1'b0);
        chk("t2:count", ctrl_a.count, 1'b0);

        // 3: write coinciding with underflow keeps START
        tick("t3w", 1, 0, 8'h09, 0, 0);
        tick("t3u", 1, 0, 8'h09, 1, 0);
        chk("t3:start", ctrl_a.start, 1'b1);

        // 4: CNT rising edges on timer A
        tick("t4w", 1, 0, 8'h21, 0, 0);
        pulses_a = 0;
        for (int i = 0; i < 10; i++) begin
            cnt = (i == 1 || i == 4 || i == 7) ? 1'b1 : 1'b0;
            tick("t4", 0, 0, 8'h00, 0, 0);
        end
        chk("t4:pulses", pulses_a, 3);

        // 5: timer B on TA underflow, then TA underflow gated by CNT
        cnt = 1'b0;
        tick("t5w", 0, 1, 8'h41, 0, 0);
        pulses_b = 0;
        for (int i = 0; i < 8; i++) tick("t5a", 0, 0, 8'h00, i[0], 0);
        chk("t5:ta", pulses_b, 4);
        tick("t5w2", 0, 1, 8'h61, 0, 0);
        pulses_b = 0;
        for (int i = 0; i < 8; i++) tick("t5b", 0, 0, 8'h00, i[0], 0);
        chk("t5:cnt0", pulses_b, 0);
        cnt = 1'b1;
        pulses_b = 0;
        for (int i = 0; i < 8; i++) tick("t5c", 0, 0, 8'h00, i[0], 0);
        chk("t5:cnt1", pulses_b, 4);

        // 6: reset mid-count with a pending CNT edge
        cnt = 1'b0;
        tick("t6w", 1, 0, 8'h01, 0, 0);
        cnt = 1'b1;
        do_reset();
        tick("t6m", 1, 0, 8'h21, 0, 0);
        pulses_a = 0;
        for (int i = 0; i < 4; i++) tick("t6", 0, 0, 8'h00, 0, 0);
        chk("t6:stale", pulses_a, 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic wa, wb, ta, tb;
            logic [7:0] d;
            if ($urandom_range(0, 3) == 0) cnt = ~cnt;
            wa = ($urandom_range(0, 7) == 0);
            wb = ($urandom_range(0, 7) == 0);
            ta = ($urandom_range(0, 3) == 0);
            tb = ($urandom_range(0, 3) == 0);
            d  = 8'($urandom);
            if ($urandom_range(0, 1) == 1) d[0] = 1'b1;
            tick("rnd", wa, wb, d, ta, tb);
            if (i == 200) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
